// File: rtl/exec_pkg.sv
// Shared opcodes, floating-point format constants and operand helpers for the execute unit.
package exec_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_ORR  = 3'b011;
   localparam logic [2:0] ALU_EOR  = 3'b100;
   localparam logic [2:0] ALU_MUL  = 3'b101;
   localparam logic [2:0] ALU_MOV  = 3'b110;
   localparam logic [2:0] ALU_ZERO = 3'b111;

   localparam int unsigned SP_EXP_W = 8;
   localparam int unsigned SP_MAN_W = 23;
   localparam int unsigned SP_BIAS  = 127;
   localparam int unsigned HP_EXP_W = 5;
   localparam int unsigned HP_MAN_W = 10;
   localparam int unsigned HP_BIAS  = 15;

   localparam logic [31:0] NAN_SP_C = 32'h7FC00000;
   localparam logic [15:0] NAN_HP_C = 16'h7E00;

   // Unpacked operand; a half-precision mantissa is left-aligned into the 23-bit field.
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
      logic        zero;
      logic        inf;
      logic        nan;
   } fp_op_t;

   function automatic fp_op_t fp_unpack(input logic [31:0] x, input logic half);
      fp_op_t     op;
      logic [7:0] emax;
      if (half) begin
         op.sign = x[15];
         op.exp  = {3'b000, x[14:10]};
         op.man  = {x[9:0], 13'h0};
         emax    = 8'((1 << HP_EXP_W) - 1);
      end else begin
         op.sign = x[31];
         op.exp  = x[30:23];
         op.man  = x[22:0];
         emax    = 8'((1 << SP_EXP_W) - 1);
      end
      op.zero = (op.exp == 8'h00);
      op.inf  = (op.exp == emax) && (op.man == '0);
      op.nan  = (op.exp == emax) && (op.man != '0);
      return op;
   endfunction

   function automatic logic [31:0] fp_pack(input logic half, input logic s,
                                           input logic [7:0] e, input logic [22:0] m);
      if (half) return {16'h0, s, e[4:0], m[22:13]};
      return {s, e, m};
   endfunction

endpackage

// File: rtl/exec_unit_fp_int_if.sv
// Operand/control and result bundle between the datapath and the execute unit.
interface exec_unit_fp_int_if;
   logic        valid_in;
   logic [31:0] A;
   logic [31:0] B;
   logic        fp_sel;
   logic [2:0]  ALUControl;
   logic        floatType;
   logic        FPUControl;
   logic        valid_out;
   logic [31:0] Result;
   logic [3:0]  Flags;

   modport master (
      output valid_in, A, B, fp_sel, ALUControl, floatType, FPUControl,
      input  valid_out, Result, Flags
   );

   modport slave (
      input  valid_in, A, B, fp_sel, ALUControl, floatType, FPUControl,
      output valid_out, Result, Flags
   );
endinterface

// File: rtl/fp_core.sv
// Combinational IEEE-754 add/multiply for single or half precision, round toward zero,
// subnormals flushed to zero.
module fp_core
   import exec_pkg::*;
#(
   parameter logic [31:0] NAN_SP = NAN_SP_C,
   parameter logic [15:0] NAN_HP = NAN_HP_C
) (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        half,
   input  logic        is_mul,
   output logic [31:0] result,
   output logic        overflow,
   output logic        invalid
);

   fp_op_t      op_a, op_b;
   int          bias, emax;
   logic [31:0] nan_val;
   logic        a_ge_b;
   logic        l_sign, s_sign;
   logic [7:0]  l_exp, s_exp, exp_diff;
   logic [22:0] l_man, s_man;
   logic [47:0] frac_l, frac_s_full, frac_s;
   logic        sticky;
   logic [48:0] add_sum, add_norm;
   int          lead;
   logic [47:0] prod;
   logic        s_res;
   int          e_res;
   logic [22:0] m_res;
   logic        take_norm;
   logic        unused_bits;

   always_comb begin
      op_a    = fp_unpack(a, half);
      op_b    = fp_unpack(b, half);
      bias    = half ? int'(HP_BIAS) : int'(SP_BIAS);
      emax    = half ? ((1 << HP_EXP_W) - 1) : ((1 << SP_EXP_W) - 1);
      nan_val = half ? {16'h0, NAN_HP} : NAN_SP;

      // Larger magnitude goes first so an effective subtraction never goes negative.
      a_ge_b   = {op_a.exp, op_a.man} >= {op_b.exp, op_b.man};
      l_sign   = a_ge_b ? op_a.sign : op_b.sign;
      l_exp    = a_ge_b ? op_a.exp  : op_b.exp;
      l_man    = a_ge_b ? op_a.man  : op_b.man;
      s_sign   = a_ge_b ? op_b.sign : op_a.sign;
      s_exp    = a_ge_b ? op_b.exp  : op_a.exp;
      s_man    = a_ge_b ? op_b.man  : op_a.man;
      exp_diff = l_exp - s_exp;

      // Shifted-out bits collapse into a sticky LSB so truncation stays exact.
      frac_l      = {1'b1, l_man, 24'h0};
      frac_s_full = {1'b1, s_man, 24'h0};
      sticky      = |(frac_s_full & ((48'h1 << exp_diff) - 48'h1));
      frac_s      = (frac_s_full >> exp_diff) | {47'h0, sticky};
      add_sum     = (l_sign == s_sign) ? {1'b0, frac_l} + {1'b0, frac_s}
                                       : {1'b0, frac_l} - {1'b0, frac_s};
      lead = 0;
      for (int i = 0; i < 49; i++) begin
         if (add_sum[i]) lead = i;
      end
      add_norm = add_sum << (48 - lead);

      prod = 48'({1'b1, op_a.man}) * 48'({1'b1, op_b.man});

      if (is_mul) begin
         s_res = op_a.sign ^ op_b.sign;
         if (prod[47]) begin
            m_res = prod[46:24];
            e_res = int'(op_a.exp) + int'(op_b.exp) - bias + 1;
         end else begin
            m_res = prod[45:23];
            e_res = int'(op_a.exp) + int'(op_b.exp) - bias;
         end
      end else begin
         s_res = l_sign;
         m_res = add_norm[47:25];
         e_res = int'(l_exp) + lead - 47;
      end

      result    = '0;
      overflow  = 1'b0;
      invalid   = 1'b0;
      take_norm = 1'b0;
      if (op_a.nan || op_b.nan) begin
         result  = nan_val;
         invalid = 1'b1;
      end else if (is_mul) begin
         if ((op_a.inf && op_b.zero) || (op_a.zero && op_b.inf)) begin
            result  = nan_val;
            invalid = 1'b1;
         end else if (op_a.inf || op_b.inf) begin
            result = fp_pack(half, s_res, 8'(emax), '0);
         end else if (op_a.zero || op_b.zero) begin
            result = fp_pack(half, s_res, 8'h00, '0);
         end else begin
            take_norm = 1'b1;
         end
      end else begin
         if (op_a.inf && op_b.inf && (op_a.sign != op_b.sign)) begin
            result  = nan_val;
            invalid = 1'b1;
         end else if (op_a.inf) begin
            result = fp_pack(half, op_a.sign, 8'(emax), '0);
         end else if (op_b.inf) begin
            result = fp_pack(half, op_b.sign, 8'(emax), '0);
         end else if (op_a.zero && op_b.zero) begin
            result = fp_pack(half, op_a.sign & op_b.sign, 8'h00, '0);
         end else if (op_a.zero) begin
            result = fp_pack(half, op_b.sign, op_b.exp, op_b.man);
         end else if (op_b.zero) begin
            result = fp_pack(half, op_a.sign, op_a.exp, op_a.man);
         end else if (add_sum == '0) begin
            result = '0;
         end else begin
            take_norm = 1'b1;
         end
      end

      if (take_norm) begin
         if (e_res >= emax) begin
            result   = fp_pack(half, s_res, 8'(emax), '0);
            overflow = 1'b1;
         end else if (e_res <= 0) begin
            result = fp_pack(half, s_res, 8'h00, '0);
         end else begin
            result = fp_pack(half, s_res, e_res[7:0], m_res);
         end
      end
   end

   // Truncated product and normalisation bits are discarded by round-toward-zero.
   assign unused_bits = ^{add_norm[48], add_norm[24:0], prod[22:0]};

endmodule

// File: rtl/exec_unit_fp_int.sv
// Execute unit: 32-bit integer ALU plus FP add/mul core, registered result and NZCV flags.
module exec_unit_fp_int
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter logic [31:0] NAN_SP = NAN_SP_C,
   parameter logic [15:0] NAN_HP = NAN_HP_C
) (
   input logic               clk,
   input logic               reset,
   exec_unit_fp_int_if.slave bus
);

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   alu_sum;
   logic             alu_c, alu_v;
   logic [31:0]      fp_res;
   logic             fp_ovf, fp_inv;
   logic             fp_n, fp_z;
   logic [WIDTH-1:0] result_d, result_q;
   logic [3:0]       flags_d, flags_q;
   logic             valid_q;

   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.ALUControl)
         ALU_ADD: begin
            alu_sum = {1'b0, bus.A} + {1'b0, bus.B};
            alu_res = alu_sum[WIDTH-1:0];
            alu_c   = alu_sum[WIDTH];
            alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
         end
         ALU_SUB: begin
            // Carry out of A + ~B + 1 is the ARM "not borrow".
            alu_sum = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
            alu_res = alu_sum[WIDTH-1:0];
            alu_c   = alu_sum[WIDTH];
            alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
         end
         ALU_AND: alu_res = bus.A & bus.B;
         ALU_ORR: alu_res = bus.A | bus.B;
         ALU_EOR: alu_res = bus.A ^ bus.B;
         ALU_MUL: alu_res = bus.A * bus.B;
         ALU_MOV: alu_res = bus.B;
         default: alu_res = '0;
      endcase
   end

   fp_core #(
      .NAN_SP (NAN_SP),
      .NAN_HP (NAN_HP)
   ) u_fp_core (
      .a        (bus.A),
      .b        (bus.B),
      .half     (bus.floatType),
      .is_mul   (bus.FPUControl),
      .result   (fp_res),
      .overflow (fp_ovf),
      .invalid  (fp_inv)
   );

   always_comb begin
      fp_n = bus.floatType ? fp_res[15] : fp_res[31];
      fp_z = bus.floatType ? (fp_res[14:0] == '0) : (fp_res[30:0] == '0);
      if (bus.fp_sel) begin
         result_d = fp_res;
         flags_d  = {fp_n, fp_z, 1'b0, fp_ovf | fp_inv};
      end else begin
         result_d = alu_res;
         flags_d  = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         valid_q <= bus.valid_in;
         if (bus.valid_in) begin
            result_q <= result_d;
            flags_q  <= flags_d;
         end
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.Result    = result_q;
   assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_exec_unit_fp_int.sv
// Bench for exec_unit_fp_int: directed cases plus random ops against an exact-arithmetic model.
module tb_exec_unit_fp_int;
   typedef logic [319:0] big_t;
   localparam int C_ZERO = 0, C_NORM = 1, C_INF = 2, C_NAN = 3;

   logic clk = 1'b0;
   logic reset;
   exec_unit_fp_int_if bus ();
   exec_unit_fp_int dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] edge_v [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
   logic [31:0] exp_res, mr, a, b;
   logic [3:0]  exp_flags, mf;
   bit          vin, fsel, half, mulc;
   logic [2:0]  op;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] r, input logic [3:0] f,
                            input bit v);
      check({tag, ".Result"}, bus.Result, r);
      check({tag, ".Flags"}, {28'h0, bus.Flags}, {28'h0, f});
      check({tag, ".valid_out"}, {31'h0, bus.valid_out}, {31'h0, v});
   endtask

   task automatic step(input bit v, input bit fs, input logic [2:0] alu, input bit hp,
                       input bit fm, input logic [31:0] x, input logic [31:0] y);
      bus.valid_in = v;  bus.fp_sel = fs; bus.ALUControl = alu;
      bus.floatType = hp; bus.FPUControl = fm; bus.A = x; bus.B = y;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc(input bit hp, input bit s, input int e,
                                       input logic [31:0] frac);
      int mw = hp ? 10 : 23;
      int ew = hp ? 5 : 8;
      return (32'(s) << (ew + mw)) | (32'(e) << mw) | frac;
   endfunction

   function automatic void decode(input bit hp, input logic [31:0] x, output int cls,
                                  output bit s, output int ex, output big_t sig);
      int mw = hp ? 10 : 23;
      int ew = hp ? 5 : 8;
      int bias = hp ? 15 : 127;
      int emax = (1 << ew) - 1;
      int eb = int'((x >> mw) & 32'(emax));
      logic [31:0] f = x & ((32'h1 << mw) - 1);
      s = x[mw + ew];
      if (eb == 0) cls = C_ZERO;
      else if (eb == emax) cls = (f != 0) ? C_NAN : C_INF;
      else cls = C_NORM;
      sig = (big_t'(1) << mw) | big_t'(f);
      ex = eb - bias - mw;
   endfunction

   // Value is mag * 2^e0 exactly; truncate to the format.
   function automatic logic [31:0] round_pack(input bit hp, input bit s, input big_t mag,
                                              input int e0, output bit ovf);
      int   mw = hp ? 10 : 23;
      int   bias = hp ? 15 : 127;
      int   emax = hp ? 31 : 255;
      int   p = 0;
      int   eb;
      big_t fr;
      for (int i = 0; i < 320; i++) if (mag[i]) p = i;
      eb  = p + e0 + bias;
      ovf = 1'b0;
      if (eb >= emax) begin
         ovf = 1'b1;
         return enc(hp, s, emax, 32'h0);
      end
      if (eb <= 0) return enc(hp, s, 0, 32'h0);
      fr = (p >= mw) ? (mag >> (p - mw)) : (mag << (mw - p));
      return enc(hp, s, eb, fr[31:0] & ((32'h1 << mw) - 1));
   endfunction

   function automatic void ref_fp(input bit hp, input bit mul, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic [3:0] fl);
      int   mw = hp ? 10 : 23;
      int   ew = hp ? 5 : 8;
      int   emax = (1 << ew) - 1;
      int   ca, cb, ea, eb, emin;
      bit   sa, sb, s, ovf, nan;
      big_t ma, mb, xa, xb, mag;
      decode(hp, x, ca, sa, ea, ma);
      decode(hp, y, cb, sb, eb, mb);
      ovf = 1'b0; nan = 1'b0; r = '0;
      if (ca == C_NAN || cb == C_NAN) nan = 1'b1;
      else if (mul) begin
         s = sa ^ sb;
         if ((ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF)) nan = 1'b1;
         else if (ca == C_INF || cb == C_INF) r = enc(hp, s, emax, 32'h0);
         else if (ca == C_ZERO || cb == C_ZERO) r = enc(hp, s, 0, 32'h0);
         else r = round_pack(hp, s, ma * mb, ea + eb, ovf);
      end else begin
         if (ca == C_INF && cb == C_INF && sa != sb) nan = 1'b1;
         else if (ca == C_INF) r = enc(hp, sa, emax, 32'h0);
         else if (cb == C_INF) r = enc(hp, sb, emax, 32'h0);
         else if (ca == C_ZERO && cb == C_ZERO) r = enc(hp, sa & sb, 0, 32'h0);
         else if (ca == C_ZERO) r = round_pack(hp, sb, mb, eb, ovf);
         else if (cb == C_ZERO) r = round_pack(hp, sa, ma, ea, ovf);
         else begin
            emin = (ea < eb) ? ea : eb;
            xa = ma << (ea - emin);
            xb = mb << (eb - emin);
            if (sa == sb) begin mag = xa + xb; s = sa; end
            else if (xa >= xb) begin mag = xa - xb; s = sa; end
            else begin mag = xb - xa; s = sb; end
            r = (mag == 0) ? 32'h0 : round_pack(hp, s, mag, emin, ovf);
         end
      end
      if (nan) r = hp ? 32'h00007E00 : 32'h7FC00000;
      fl = {r[mw + ew], (r & ((32'h1 << (mw + ew)) - 1)) == 0, 1'b0, ovf | nan};
   endfunction

   function automatic void ref_int(input logic [2:0] alu, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] r,
                                   output logic [3:0] fl);
      longint u, ss;
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      bit c = 1'b0, v = 1'b0;
      case (alu)
         3'd0: begin
            u = longint'(x) + longint'(y); r = u[31:0]; c = u > 64'hFFFFFFFF;
            ss = sx + sy; v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
         end
         3'd1: begin
            u = longint'(x) - longint'(y); r = u[31:0]; c = x >= y;
            ss = sx - sy; v = ss > 64'sd2147483647 || ss < -64'sd2147483648;
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: begin u = longint'(x) * longint'(y); r = u[31:0]; end
         3'd6: r = y;
         default: r = 32'h0;
      endcase
      fl = {r[31], r == 32'h0, c, v};
   endfunction

   function automatic logic [31:0] rand_fp(input bit hp);
      int mw = hp ? 10 : 23;
      int ew = hp ? 5 : 8;
      int bias = hp ? 15 : 127;
      int emax = (1 << ew) - 1;
      int k = int'($urandom_range(0, 15));
      int e;
      logic [31:0] f = $urandom & ((32'h1 << mw) - 1);
      case (k)
         0: begin e = 0; f = 32'h0; end
         1: e = 0;
         2: begin e = emax; f = 32'h0; end
         3: begin e = emax; f = f | 32'h1; end
         4, 5, 6, 7: e = int'($urandom_range(1, 32'(emax - 1)));
         default: e = bias + int'($urandom_range(0, 6)) - 3;
      endcase
      return enc(hp, 1'($urandom), e, f) | (hp ? ($urandom & 32'hFFFF0000) : 32'h0);
   endfunction

   initial begin
      reset = 1'b0;
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_out("reset", 32'h0, 4'h0, 1'b0);
      #3 reset = 1'b1;

      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1);
      check_out("add_ovf", 32'h80000000, 4'b1001, 1'b1);
      step(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'd5, 32'd5);
      check_out("sub_eq", 32'h0, 4'b0110, 1'b1);
      step(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'd3, 32'd5);
      check_out("sub_neg", 32'hFFFFFFFE, 4'b1000, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000);
      check_out("sp_add", 32'h40400000, 4'b0000, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 32'h3FC00000, 32'hC0000000);
      check_out("sp_mul", 32'hC0400000, 4'b1000, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 32'h00003C00, 32'h00003C00);
      check_out("hp_add", 32'h00004000, 4'b0000, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 32'h00007BFF, 32'h00007BFF);
      check_out("hp_mul_ovf", 32'h00007C00, 4'b0001, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000);
      check_out("inf_minus_inf", 32'h7FC00000, 4'b0001, 1'b1);
      step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h3F800000, 32'hBF800000);
      check_out("cancel", 32'h0, 4'b0100, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h12345678, 32'h1);
      check_out("hold", 32'h0, 4'b0100, 1'b0);

      exp_res = 32'h0;
      exp_flags = 4'b0100;
      for (int i = 0; i < 400; i++) begin
         vin  = ($urandom_range(0, 7) != 0);
         fsel = 1'($urandom);
         half = 1'($urandom);
         mulc = 1'($urandom);
         op   = 3'($urandom);
         if (fsel) begin
            a = rand_fp(half);
            b = ($urandom_range(0, 3) == 0) ? (a ^ (half ? 32'h8000 : 32'h80000000)
                                                  ^ 32'($urandom_range(0, 3)))
                                               : rand_fp(half);
            ref_fp(half, mulc, a, b, mr, mf);
         end else begin
            a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
            ref_int(op, a, b, mr, mf);
         end
         if (vin) begin
            exp_res = mr;
            exp_flags = mf;
         end
         step(vin, fsel, op, half, mulc, a, b);
         check_out(fsel ? "rand_fp" : "rand_int", exp_res, exp_flags, vin);
      end

      step(1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 32'h0, 32'hA5A5A5A5);
      check_out("mov", 32'hA5A5A5A5, 4'b1000, 1'b1);
      #2 reset = 1'b0;
      #1 check_out("async_reset", 32'h0, 4'h0, 1'b0);
      #2 reset = 1'b1;
      step(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF);
      check_out("post_reset_idle", 32'h0, 4'h0, 1'b0);
      step(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF);
      check_out("post_reset_idle2", 32'h0, 4'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
